// File: rtl/conv_out_buffer.sv
// Bias add with saturation and optional ReLU, then a FIFO to the next layer.
// blob_dout_rdy is registered and sized so every beat in flight still fits.
module conv_out_buffer #(
  parameter int DW      = 16,
  parameter int KPF     = 2,
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int SLACK   = 10,
  parameter int RELU_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic              in_eop,
  input  logic [KPF*DW-1:0] in_data,
  input  logic [KPF*DW-1:0] in_bias,
  output logic              blob_dout_rdy,
  output logic              out_en,
  output logic              out_eop,
  output logic [KPF*DW-1:0] out_data,
  input  logic              out_rdy,
  output logic [AW:0]       level,
  output logic              overflow
);
  localparam int W = KPF * DW;
  localparam logic [DW-1:0]   SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]   SAT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [AW+1:0]   RDY_LIM = (AW+2)'(DEPTH - SLACK);
  localparam logic [AW:0]     FULL_LVL = (AW+1)'(DEPTH);

  logic signed [DW:0] s;
  logic [W-1:0]       lane_res;

  // One extra bit of headroom makes the true sign of the sum s[DW].
  always_comb begin
    s        = '0;
    lane_res = '0;
    for (int i = 0; i < KPF; i++) begin
      s = $signed({in_data[i*DW+DW-1], in_data[i*DW +: DW]})
        + $signed({in_bias[i*DW+DW-1], in_bias[i*DW +: DW]});
      if (s[DW] != s[DW-1])
        lane_res[i*DW +: DW] = s[DW] ? SAT_MIN : SAT_MAX;
      else
        lane_res[i*DW +: DW] = s[DW-1:0];
      if (RELU_EN != 0 && s[DW])
        lane_res[i*DW +: DW] = '0;
    end
  end

  logic [W-1:0]  d1;
  logic          v1;
  logic          eop1;
  logic [W:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          pop;
  logic          push;
  logic          full;
  logic [AW+1:0] used;

  // Pop is decided from registered level, so a just-pushed entry waits a cycle.
  assign pop  = (level != '0) && out_rdy;
  assign full = (level == FULL_LVL);
  assign push = v1 && (!full || pop);
  assign used = {1'b0, level} + (AW+2)'(v1);

  always_ff @(posedge clk) begin
    if (rst) begin
      d1            <= '0;
      v1            <= 1'b0;
      eop1          <= 1'b0;
      wp            <= '0;
      rp            <= '0;
      level         <= '0;
      overflow      <= 1'b0;
      out_en        <= 1'b0;
      out_eop       <= 1'b0;
      out_data      <= '0;
      blob_dout_rdy <= 1'b0;
    end else begin
      d1   <= lane_res;
      v1   <= in_en;
      eop1 <= in_eop & in_en;
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)
        level <= level + 1'b1;
      else if (pop && !push)
        level <= level - 1'b1;
      if (v1 && !push) overflow <= 1'b1;
      out_en <= pop;
      if (pop) begin
        out_data <= mem[rp][W-1:0];
        out_eop  <= mem[rp][W];
      end
      blob_dout_rdy <= (used < RDY_LIM);
    end
  end

  // When full, push and pop share one slot: the read above sees the old entry.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {eop1, d1};
  end
endmodule

// File: tb/tb_conv_out_buffer.sv
// Directed bench for conv_out_buffer: ReLU and non-ReLU instances share inputs.
module tb_conv_out_buffer;
  logic        clk;
  logic        rst;
  logic        in_en;
  logic        in_eop;
  logic [31:0] in_data;
  logic [31:0] in_bias;
  logic        out_rdy;
  logic        blob_dout_rdy, out_en, out_eop, overflow;
  logic [31:0] out_data;
  logic [5:0]  level;
  logic        nr_blob_dout_rdy, nr_out_en, nr_out_eop, nr_overflow;
  logic [31:0] nr_out_data;
  logic [5:0]  nr_level;

  int n_cmp = 0;
  int n_fail = 0;
  logic [32:0] exp_q [$];

  conv_out_buffer #(.RELU_EN(1)) u_dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_eop(in_eop), .in_data(in_data),
    .in_bias(in_bias), .blob_dout_rdy(blob_dout_rdy), .out_en(out_en),
    .out_eop(out_eop), .out_data(out_data), .out_rdy(out_rdy), .level(level),
    .overflow(overflow));

  conv_out_buffer #(.RELU_EN(0)) u_dut_nr (
    .clk(clk), .rst(rst), .in_en(in_en), .in_eop(in_eop), .in_data(in_data),
    .in_bias(in_bias), .blob_dout_rdy(nr_blob_dout_rdy), .out_en(nr_out_en),
    .out_eop(nr_out_eop), .out_data(nr_out_data), .out_rdy(out_rdy), .level(nr_level),
    .overflow(nr_overflow));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pk(input logic signed [15:0] l0, input logic signed [15:0] l1);
    return {l1, l0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_en = 1'b1; in_eop = 1'b1; in_data = pk(7, 7); in_bias = '0; out_rdy = 1'b1;
    cyc(3);
    n_cmp++; if (level !== 6'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL reset_out_en: got %b want 0", out_en); end
    n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (blob_dout_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", blob_dout_rdy); end
    rst = 1'b0; in_en = 1'b0; in_eop = 1'b0;
    cyc(1);
    n_cmp++; if (blob_dout_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_rise: got %b want 1", blob_dout_rdy); end
    n_cmp++; if (level !== 6'd0) begin n_fail++; $display("FAIL reset_ignored_input: level %0d want 0", level); end
  endtask

  task automatic test_basic;
    out_rdy = 1'b1;
    cyc(5);
    in_en = 1'b1; in_eop = 1'b1; in_data = pk(100, -50); in_bias = pk(5, 20);
    cyc(1);
    in_en = 1'b0; in_eop = 1'b0;
    n_cmp++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL basic_lat1: out_en %b want 0", out_en); end
    cyc(1);
    n_cmp++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL basic_lat2: out_en %b want 0", out_en); end
    cyc(1);
    n_cmp++; if (out_en !== 1'b1) begin n_fail++; $display("FAIL basic_lat3: out_en %b want 1", out_en); end
    n_cmp++; if (out_data !== pk(105, 0)) begin n_fail++; $display("FAIL basic_relu_data: got %h want %h", out_data, pk(105, 0)); end
    n_cmp++; if (out_eop !== 1'b1) begin n_fail++; $display("FAIL basic_eop: got %b want 1", out_eop); end
    n_cmp++; if (nr_out_data !== pk(105, -30)) begin n_fail++; $display("FAIL basic_norelu_data: got %h want %h", nr_out_data, pk(105, -30)); end
    cyc(1);
    n_cmp++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: out_en %b want 0", out_en); end
    n_cmp++; if (out_data !== pk(105, 0)) begin n_fail++; $display("FAIL basic_hold: got %h want %h", out_data, pk(105, 0)); end
  endtask

  task automatic test_saturation;
    in_en = 1'b1; in_eop = 1'b0; in_data = pk(32767, -32768); in_bias = pk(10, -1);
    cyc(1);
    in_data = pk(-100, 32760); in_bias = pk(-32768, 100);
    cyc(1);
    in_en = 1'b0;
    cyc(1);
    n_cmp++; if (out_en !== 1'b1 || out_data !== pk(32767, 0)) begin n_fail++; $display("FAIL sat_a_relu: en %b got %h want %h", out_en, out_data, pk(32767, 0)); end
    n_cmp++; if (nr_out_data !== pk(32767, -32768)) begin n_fail++; $display("FAIL sat_a_norelu: got %h want %h", nr_out_data, pk(32767, -32768)); end
    cyc(1);
    n_cmp++; if (out_en !== 1'b1 || out_data !== pk(0, 32767)) begin n_fail++; $display("FAIL sat_b_relu: en %b got %h want %h", out_en, out_data, pk(0, 32767)); end
    n_cmp++; if (nr_out_data !== pk(-32768, 32767)) begin n_fail++; $display("FAIL sat_b_norelu: got %h want %h", nr_out_data, pk(-32768, 32767)); end
    n_cmp++; if (out_eop !== 1'b0) begin n_fail++; $display("FAIL sat_eop: got %b want 0", out_eop); end
    cyc(1);
  endtask

  task automatic test_backpressure;
    int fall_idx;
    fall_idx = -1;
    out_rdy = 1'b0;
    cyc(2);
    for (int i = 0; i < 32; i++) begin
      if (blob_dout_rdy === 1'b0 && fall_idx < 0) fall_idx = i;
      in_en = 1'b1; in_eop = (i == 31); in_data = pk(16'(i), 16'(i + 1000)); in_bias = '0;
      exp_q.push_back({(i == 31) ? 1'b1 : 1'b0, pk(16'(i), 16'(i + 1000))});
      cyc(1);
    end
    in_en = 1'b0; in_eop = 1'b0;
    n_cmp++; if (fall_idx !== 23) begin n_fail++; $display("FAIL bp_rdy_fall: fell before beat %0d want 23", fall_idx); end
    cyc(3);
    n_cmp++; if (level !== 6'd32) begin n_fail++; $display("FAIL bp_level: got %0d want 32", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_overflow: got %b want 0", overflow); end
    n_cmp++; if (blob_dout_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_low: got %b want 0", blob_dout_rdy); end
  endtask

  task automatic test_full_push_pop;
    logic [32:0] head;
    in_en = 1'b1; in_data = pk(500, 600); in_bias = '0;
    cyc(1);
    in_en = 1'b0; out_rdy = 1'b1;
    cyc(1);
    out_rdy = 1'b0;
    head = exp_q.pop_front();
    exp_q.push_back({1'b0, pk(500, 600)});
    n_cmp++; if (level !== 6'd32) begin n_fail++; $display("FAIL full_pp_level: got %0d want 32", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_overflow: got %b want 0", overflow); end
    n_cmp++; if (out_en !== 1'b1 || {out_eop, out_data} !== head) begin n_fail++; $display("FAIL full_pp_head: en %b got %h want %h", out_en, {out_eop, out_data}, head); end
  endtask

  task automatic test_overflow;
    in_en = 1'b1; in_data = pk(777, 777); in_bias = '0;
    cyc(1);
    in_en = 1'b0;
    cyc(1);
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_cmp++; if (level !== 6'd32) begin n_fail++; $display("FAIL ovf_level: got %0d want 32", level); end
    cyc(4);
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_drain;
    int cnt;
    cnt = 0;
    out_rdy = 1'b1;
    for (int k = 0; k < 80; k++) begin
      cyc(1);
      if (out_en === 1'b1) begin
        n_cmp++;
        if (cnt >= exp_q.size()) begin n_fail++; $display("FAIL drain_extra: unexpected beat %h", {out_eop, out_data}); end
        else if ({out_eop, out_data} !== exp_q[cnt]) begin n_fail++; $display("FAIL drain_beat%0d: got %h want %h", cnt, {out_eop, out_data}, exp_q[cnt]); end
        cnt++;
      end
    end
    n_cmp++; if (cnt !== 32) begin n_fail++; $display("FAIL drain_count: got %0d want 32", cnt); end
    n_cmp++; if (level !== 6'd0) begin n_fail++; $display("FAIL drain_level: got %0d want 0", level); end
    n_cmp++; if (blob_dout_rdy !== 1'b1) begin n_fail++; $display("FAIL drain_rdy: got %b want 1", blob_dout_rdy); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drain_ovf_sticky: got %b want 1", overflow); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    int cnt;
    out_rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_en = 1'b1; in_eop = 1'b0; in_data = pk(16'(i + 40), 16'(i + 50)); in_bias = '0;
      cyc(1);
    end
    in_en = 1'b0;
    cyc(2);
    n_cmp++; if (level !== 6'd7) begin n_fail++; $display("FAIL rmf_fill: level %0d want 7", level); end
    rst = 1'b1; in_en = 1'b1; in_data = pk(99, 99);
    cyc(1);
    rst = 1'b0; in_en = 1'b0;
    n_cmp++; if (level !== 6'd0) begin n_fail++; $display("FAIL rmf_level: got %0d want 0", level); end
    n_cmp++; if (out_en !== 1'b0) begin n_fail++; $display("FAIL rmf_out_en: got %b want 0", out_en); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmf_overflow: got %b want 0", overflow); end
    n_cmp++; if (blob_dout_rdy !== 1'b0) begin n_fail++; $display("FAIL rmf_rdy_low: got %b want 0", blob_dout_rdy); end
    cyc(1);
    n_cmp++; if (blob_dout_rdy !== 1'b1) begin n_fail++; $display("FAIL rmf_rdy_rise: got %b want 1", blob_dout_rdy); end
    out_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_en = 1'b1; in_eop = (j == 2); in_data = pk(16'(j + 1), -16'(j + 1)); in_bias = '0;
      exp_q.push_back({(j == 2) ? 1'b1 : 1'b0, pk(16'(j + 1), 0)});
      cyc(1);
    end
    in_en = 1'b0; in_eop = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_en === 1'b1) begin
        n_cmp++;
        if (cnt >= exp_q.size()) begin n_fail++; $display("FAIL rmf_extra: unexpected beat %h", {out_eop, out_data}); end
        else if ({out_eop, out_data} !== exp_q[cnt]) begin n_fail++; $display("FAIL rmf_beat%0d: got %h want %h", cnt, {out_eop, out_data}, exp_q[cnt]); end
        cnt++;
      end
      cyc(1);
    end
    n_cmp++; if (cnt !== 3) begin n_fail++; $display("FAIL rmf_count: got %0d want 3", cnt); end
  endtask

  initial begin
    rst = 1'b1; in_en = 1'b0; in_eop = 1'b0; in_data = '0; in_bias = '0; out_rdy = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_full_push_pop();
    test_overflow();
    test_drain();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
